rr_chan_arbiter: RTL and testbench

//  Round-robin arbiter sharing one valid/ready output channel (typically feeding a transparent skid buffer)

---
 rtl/rr_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/rr_chan_arbiter.sv | 107 ++++++++++
 tb/tb_rr_chan_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state type, id width helper and counter width for rr_chan_arbiter
package rr_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int PERF_CNT_W = 32;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating priority encoder, highest priority at ptr
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   gnt_id,
    output logic            any
);

    logic [IW-1:0] idx;

    // Scan from farthest to nearest so the requester closest to ptr is the last writer.
    always_comb begin
        gnt_id = '0;
        idx    = '0;
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/rr_chan_arbiter.sv
// rtl/rr_chan_arbiter.sv - packet-granular round-robin arbiter onto one valid/ready channel
// RR_ARB_PERF_EN adds per-requester beat counters and a stall counter.
module rr_chan_arbiter
    import rr_arb_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LOCK   = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NREQ-1:0]            in_valid,
    input  logic [NREQ*DATA_WIDTH-1:0] in_data,
    input  logic [NREQ-1:0]            in_last,
    output logic [NREQ-1:0]            in_ready,
    output logic                       out_valid,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last,
    output logic [id_w(NREQ)-1:0]      out_id,
`ifdef RR_ARB_PERF_EN
    output logic [NREQ*PERF_CNT_W-1:0] perf_beats,
    output logic [PERF_CNT_W-1:0]      perf_stall,
`endif
    input  logic                       out_ready
);

    localparam int IW = id_w(NREQ);

    arb_state_t    state, state_n;
    logic [IW-1:0] rr_ptr, rr_ptr_n;
    logic [IW-1:0] lock_id, lock_id_n;
    logic [IW-1:0] pick_id, grant;
    logic          pick_any, fire, end_beat;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (in_valid),
        .ptr    (rr_ptr),
        .gnt_id (pick_id),
        .any    (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            lock_id <= '0;
        end else begin
            state   <= state_n;
            rr_ptr  <= rr_ptr_n;
            lock_id <= lock_id_n;
        end
    end

    always_comb begin
        grant     = (state == LOCKED) ? lock_id : pick_id;
        out_valid = rstn && ((state == LOCKED) ? in_valid[grant] : pick_any);
        out_data  = in_data[grant*DATA_WIDTH +: DATA_WIDTH];
        out_last  = in_last[grant];
        out_id    = grant;
        in_ready  = '0;
        in_ready[grant] = rstn && out_ready;
        fire      = out_valid && out_ready;
        end_beat  = fire && (out_last || (PKT_LOCK == 0));

        state_n   = state;
        rr_ptr_n  = rr_ptr;
        lock_id_n = lock_id;
        // A stalled first beat also locks, which keeps out_data stable until it fires.
        if (end_beat) begin
            state_n  = IDLE;
            rr_ptr_n = (grant == IW'(NREQ - 1)) ? '0 : grant + IW'(1);
        end else if (state == IDLE && out_valid) begin
            state_n   = LOCKED;
            lock_id_n = grant;
        end
    end

`ifdef RR_ARB_PERF_EN
    logic [PERF_CNT_W-1:0] beats_q [NREQ];
    logic [PERF_CNT_W-1:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NREQ; i++) begin
                beats_q[i] <= '0;
            end
            stall_q <= '0;
        end else begin
            if (fire) begin
                beats_q[grant] <= beats_q[grant] + PERF_CNT_W'(1);
            end
            if (out_valid && !out_ready) begin
                stall_q <= stall_q + PERF_CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_perf
        assign perf_beats[g*PERF_CNT_W +: PERF_CNT_W] = beats_q[g];
    end
    assign perf_stall = stall_q;
`endif

endmodule

// File: tb/tb_rr_chan_arbiter.sv
// tb/tb_rr_chan_arbiter.sv - scoreboard bench for rr_chan_arbiter with a packet-level reference model
`timescale 1ns/1ps
module tb_rr_chan_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn = 1'b0;
    logic [N-1:0]  in_valid = '0, in_last = '0, in_ready;
    logic [N*DW-1:0] in_data = '0;
    logic          out_valid, out_last;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;

    logic          b_rstn = 1'b0;
    logic [1:0]    b_in_valid = '0, b_in_last = '0, b_in_ready;
    logic [2*DW-1:0] b_in_data = '0;
    logic          b_out_valid, b_out_last;
    logic          b_out_ready = 1'b1;
    logic [DW-1:0] b_out_data;
    logic [0:0]    b_out_id;

`ifdef RR_ARB_PERF_EN
    logic [N*32-1:0] a_perf_beats;
    logic [31:0]     a_perf_stall;
    logic [2*32-1:0] b_perf_beats;
    logic [31:0]     b_perf_stall;
`endif

    rr_chan_arbiter #(.NREQ(N), .DATA_WIDTH(DW), .PKT_LOCK(1)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
`ifdef RR_ARB_PERF_EN
        .perf_beats(a_perf_beats),
        .perf_stall(a_perf_stall),
`endif
        .out_ready (out_ready)
    );

    rr_chan_arbiter #(.NREQ(2), .DATA_WIDTH(DW), .PKT_LOCK(0)) u_dut_nolock (
        .clk       (clk),
        .rstn      (b_rstn),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_last   (b_in_last),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_id    (b_out_id),
`ifdef RR_ARB_PERF_EN
        .perf_beats(b_perf_beats),
        .perf_stall(b_perf_stall),
`endif
        .out_ready (b_out_ready)
    );

    int     errors = 0;
    int     checks = 0;
    beat_t  src_q [N][$];
    beat_t  exp_q [N][$];
    logic [N-1:0] pres = '0;
    logic [N-1:0] acc  = '0;
    int     wcnt [N];
    int     rdy_pct = 100;
    bit     rst_req = 1'b1;
    bit     rst_prev = 1'b0;
    bit     b_done = 1'b0;
    int     log_id [$];
    int     log_cyc [$];
    int     cyc = 0;
    int     seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Driver: presents queued beats, honours per-beat idle gaps, applies reset and out_ready.
    initial begin
        beat_t db;
        for (int i = 0; i < N; i++) wcnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst_req && !rst_prev) begin
                for (int i = 0; i < N; i++) begin
                    src_q[i].delete();
                    exp_q[i].delete();
                    wcnt[i] = 0;
                end
                pres = '0;
            end
            rst_prev  = rst_req;
            rstn      = !rst_req;
            out_ready = ($urandom_range(99) < rdy_pct);
            for (int i = 0; i < N; i++) begin
                if (pres[i] && acc[i]) pres[i] = 1'b0;
                if (!pres[i] && src_q[i].size() > 0) begin
                    if (wcnt[i] < src_q[i][0].gap) begin
                        wcnt[i]++;
                    end else begin
                        db = src_q[i].pop_front();
                        wcnt[i] = 0;
                        pres[i] = 1'b1;
                        in_data[i*DW +: DW] = db.data;
                        in_last[i] = db.last;
                        exp_q[i].push_back(db);
                    end
                end
            end
            in_valid = pres;
        end
    end

    // Monitor: reference arbitration from the rules (owner or none, rotating pointer), scoreboard pop on fire.
    initial begin
        beat_t mb;
        bit    m_locked;
        int    m_lock, m_ptr, eid, c;
        bit    ev;
        m_locked = 0; m_lock = 0; m_ptr = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                m_locked = 0; m_lock = 0; m_ptr = 0;
                acc = '0;
                chk("rst_out_valid", 64'(out_valid), 64'(0));
                chk("rst_in_ready", 64'(in_ready), 64'(0));
            end else begin
                ev = 0; eid = 0;
                if (m_locked) begin
                    eid = m_lock;
                    ev  = in_valid[m_lock];
                end else begin
                    for (int k = 0; k < N; k++) begin
                        c = (m_ptr + k) % N;
                        if (!ev && in_valid[c]) begin
                            ev = 1; eid = c;
                        end
                    end
                end
                chk("out_valid", 64'(out_valid), 64'(ev));
                if (ev || m_locked)
                    chk("in_ready", 64'(in_ready), out_ready ? (64'(1) << eid) : 64'(0));
                if (ev) begin
                    chk("out_id", 64'(out_id), 64'(eid));
                    if (exp_q[eid].size() == 0) begin
                        chk("sb_nonempty", 64'(0), 64'(1));
                    end else begin
                        chk("out_data", 64'(out_data), 64'(exp_q[eid][0].data));
                        chk("out_last", 64'(out_last), 64'(exp_q[eid][0].last));
                        if (out_ready) begin
                            mb = exp_q[eid].pop_front();
                            log_id.push_back(eid);
                            log_cyc.push_back(cyc);
                            if (mb.last) begin
                                m_locked = 0;
                                m_ptr = (eid + 1) % N;
                            end else if (!m_locked) begin
                                m_locked = 1; m_lock = eid;
                            end
                        end else if (!m_locked) begin
                            m_locked = 1; m_lock = eid;
                        end
                    end
                end
                acc = in_valid & in_ready;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic push_pkt(input int r, input int len, input int gap0, input int gap_at, input int gap_len);
        beat_t pb;
        for (int k = 0; k < len; k++) begin
            seq++;
            pb.data = (32'(r) << 28) | 32'(seq);
            pb.last = (k == len - 1);
            pb.gap  = (k == 0) ? gap0 : ((k == gap_at) ? gap_len : 0);
            src_q[r].push_back(pb);
        end
    endtask

    task automatic wait_log(input string name, input int n, input int budget);
        for (int t = 0; t < budget && log_id.size() < n; t++) step(1);
        chk({name, "_timeout"}, 64'(log_id.size() >= n), 64'(1));
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit busy;
        busy = 1;
        for (int t = 0; t < budget && busy; t++) begin
            step(1);
            busy = (pres != '0);
            for (int i = 0; i < N; i++)
                if (src_q[i].size() != 0 || exp_q[i].size() != 0) busy = 1;
        end
        chk({name, "_idle_timeout"}, 64'(busy), 64'(0));
    endtask

    task automatic expect_seq(input string name, input int n, input int ids);
        chk({name, "_len"}, 64'(log_id.size()), 64'(n));
        for (int k = 0; k < n && k < log_id.size(); k++)
            chk(name, 64'(log_id[k]), 64'((ids >> (4 * (n - 1 - k))) & 15));
    endtask

    // Main sequence for the PKT_LOCK=1 instance.
    initial begin
        int total;
        step(2);
        for (int r = 0; r < N; r++) push_pkt(r, 1, 0, 0, 0);
        push_pkt(0, 1, 0, 0, 0);
        step(3);
        chk("t1_rst_out_valid", 64'(out_valid), 64'(0));
        chk("t1_rst_in_ready", 64'(in_ready), 64'(0));
        log_id.delete(); log_cyc.delete();
        rst_req = 0;
        wait_log("t2", 5, 50);
        expect_seq("t2_rotation", 5, 'h01230);
        for (int k = 1; k < 5 && k < log_cyc.size(); k++)
            chk("t2_consecutive", 64'(log_cyc[k] - log_cyc[k-1]), 64'(1));
        wait_idle("t2", 50);

        log_id.delete();
        push_pkt(1, 3, 0, 0, 0);
        push_pkt(2, 1, 0, 0, 0);
        wait_log("t3", 4, 50);
        expect_seq("t3_lock", 4, 'h1112);
        wait_idle("t3", 50);

        log_id.delete();
        rdy_pct = 0;
        push_pkt(3, 2, 0, 0, 0);
        step(2);
        push_pkt(0, 1, 0, 0, 0);
        step(3);
        chk("t4_stall_no_fire", 64'(log_id.size()), 64'(0));
        rdy_pct = 100;
        wait_log("t4", 3, 50);
        expect_seq("t4_stall", 3, 'h330);
        wait_idle("t4", 50);

        log_id.delete();
        push_pkt(2, 3, 0, 1, 2);
        push_pkt(0, 1, 0, 0, 0);
        wait_log("t5", 4, 50);
        expect_seq("t5_bubble", 4, 'h2220);
        wait_idle("t5", 50);

        log_id.delete();
        push_pkt(1, 3, 0, 0, 0);
        wait_log("t7", 1, 50);
        rst_req = 1;
        step(2);
        log_id.delete();
        push_pkt(3, 1, 0, 0, 0);
        push_pkt(0, 1, 0, 0, 0);
        step(1);
        rst_req = 0;
        wait_log("t7", 2, 50);
        expect_seq("t7_reset_mid_pkt", 2, 'h03);
        wait_idle("t7", 50);

        log_id.delete();
        rdy_pct = 70;
        total = 0;
        for (int p = 0; p < 25; p++) begin
            for (int r = 0; r < N; r++) begin
                int len;
                len = $urandom_range(4, 1);
                total += len;
                push_pkt(r, len, $urandom_range(2), $urandom_range(3, 1), $urandom_range(2));
            end
        end
        wait_idle("rand", 20000);
        chk("rand_beats", 64'(log_id.size()), 64'(total));

        for (int t = 0; t < 1000 && !b_done; t++) step(1);
        chk("nolock_done", 64'(b_done), 64'(1));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // PKT_LOCK=0 instance: two always-valid requesters must alternate every beat.
    initial begin
        int cnt [2];
        bit adv [2];
        int fires, exp_id;
        cnt[0] = 0; cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        b_rstn = 1'b1;
        for (int r = 0; r < 2; r++) begin
            b_in_valid[r] = 1'b1;
            b_in_data[r*DW +: DW] = 32'(r * 256);
            b_in_last[r] = 1'b0;
        end
        fires = 0; exp_id = 0;
        for (int c = 0; c < 40 && fires < 8; c++) begin
            @(negedge clk);
            adv[0] = 0; adv[1] = 0;
            if (b_out_valid && b_out_ready) begin
                chk("t6_id", 64'(b_out_id), 64'(exp_id));
                chk("t6_data", 64'(b_out_data), 64'(exp_id * 256 + cnt[exp_id]));
                fires++;
                exp_id = 1 - exp_id;
            end
            for (int r = 0; r < 2; r++) adv[r] = b_in_valid[r] && b_in_ready[r];
            @(posedge clk);
            #1;
            for (int r = 0; r < 2; r++) begin
                if (adv[r]) begin
                    cnt[r]++;
                    if (cnt[r] == 4) begin
                        b_in_valid[r] = 1'b0;
                    end else begin
                        b_in_data[r*DW +: DW] = 32'(r * 256 + cnt[r]);
                        b_in_last[r] = (cnt[r] == 3);
                    end
                end
            end
        end
        chk("t6_fires", 64'(fires), 64'(8));
`ifdef RR_ARB_PERF_EN
        @(negedge clk);
        chk("t6_perf_beats0", 64'(b_perf_beats[31:0]), 64'(4));
        chk("t6_perf_beats1", 64'(b_perf_beats[63:32]), 64'(4));
        chk("t6_perf_stall0", 64'(b_perf_stall), 64'(0));
        @(posedge clk);
        #1;
        b_out_ready = 1'b0;
        b_in_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t6_perf_stall3", 64'(b_perf_stall), 64'(3));
        chk("t6_perf_beats0_hold", 64'(b_perf_beats[31:0]), 64'(4));
`endif
        b_done = 1'b1;
    end

endmodule
